// File: rtl/smpl_pkg.sv
// smpl_pkg: state encoding and first-error codes shared by the smpl pair checker.
package smpl_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, SYNC = 2'd1, TRACK = 2'd2, ERROR = 2'd3} chk_state_e;
   localparam logic [1:0] ERR_TOGGLE = 2'b10;
   localparam logic [1:0] ERR_PAIR   = 2'b01;
endpackage

// File: rtl/smpl_pair_checker_sat_cnt.sv
// sat_cnt: up-counter that sticks at all-ones, with synchronous clear.
module sat_cnt #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] q,
   output logic         at_max
);
   logic [W-1:0] q_q, q_d;
   assign q      = q_q;
   assign at_max = &q_q;
   always_comb q_d = clr ? '0 : (inc && !at_max) ? q_q + 1'b1 : q_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) q_q <= '0;
      else        q_q <= q_d;
endmodule

// File: rtl/smpl_pair_checker.sv
// smpl_pair_checker: scoreboards the smpl toggle stage (a toggles, b follows a),
// counting passes/errors, capturing the first error and latching a sticky fail.
module smpl_pair_checker import smpl_pkg::*; #(
   parameter int CNT_W     = 16,
   parameter int ERR_LIMIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic             a,
   input  logic             b,
   output chk_state_e       state,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] first_err_cyc,
   output logic [1:0]       first_err_code,
   output logic             err_pulse,
   output logic             fail
);
   chk_state_e       state_q, state_d;
   logic             a_q, a_d;
   logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
   logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
   logic [CNT_W-1:0] first_err_cyc_q, first_err_cyc_d;
   logic [1:0]       first_err_code_q, first_err_code_d;
   logic             err_pulse_q, err_pulse_d;
   logic             chk, err, first, limit_hit, err_at_max;
   logic [1:0]       code;

   sat_cnt #(.W(CNT_W)) u_err_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .inc    (err),
      .clr    (clr),
      .q      (err_cnt),
      .at_max (err_at_max)
   );

   always_comb begin
      code      = ((a == a_q) ? ERR_TOGGLE : 2'b00) | ((b != a) ? ERR_PAIR : 2'b00);
      chk       = !clr && en && state_q == TRACK;
      err       = chk && code != 2'b00;
      first     = err && err_cnt == '0;
      limit_hit = err && !err_at_max && ({1'b0, err_cnt} + 1'b1 == (CNT_W+1)'(ERR_LIMIT));
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;

   always_comb
      state_d = clr                ? IDLE :
                state_q == IDLE    ? (en ? SYNC : IDLE) :
                state_q == SYNC    ? (en ? TRACK : IDLE) :
                state_q == TRACK   ? (!en ? IDLE : limit_hit ? ERROR : TRACK) :
                ERROR;

   always_comb begin
      state          = state_q;
      fail           = state_q == ERROR;
      pass_cnt       = pass_cnt_q;
      first_err_cyc  = first_err_cyc_q;
      first_err_code = first_err_code_q;
      err_pulse      = err_pulse_q;
   end

   // cyc_cnt is zeroed while in SYNC so every fresh TRACK run starts counting at 0
   always_comb begin
      a_d              = a;
      pass_cnt_d       = clr ? '0 : (chk && !err) ? pass_cnt_q + 1'b1 : pass_cnt_q;
      cyc_cnt_d        = (clr || state_q == SYNC) ? '0 : chk ? cyc_cnt_q + 1'b1 : cyc_cnt_q;
      first_err_cyc_d  = clr ? '0 : first ? cyc_cnt_q : first_err_cyc_q;
      first_err_code_d = clr ? 2'b00 : first ? code : first_err_code_q;
      err_pulse_d      = err;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         a_q              <= 1'b0;
         pass_cnt_q       <= '0;
         cyc_cnt_q        <= '0;
         first_err_cyc_q  <= '0;
         first_err_code_q <= 2'b00;
         err_pulse_q      <= 1'b0;
      end else begin
         a_q              <= a_d;
         pass_cnt_q       <= pass_cnt_d;
         cyc_cnt_q        <= cyc_cnt_d;
         first_err_cyc_q  <= first_err_cyc_d;
         first_err_code_q <= first_err_code_d;
         err_pulse_q      <= err_pulse_d;
      end
endmodule

// File: tb/tb_smpl_pair_checker.sv
// tb_smpl_pair_checker: directed scenarios plus random traffic against a behavioural model.
module tb_smpl_pair_checker;
   import smpl_pkg::*;
   localparam int W = 5, LIM = 4, MODV = 1 << W, MAXV = MODV - 1;

   logic clk = 0, rst_n = 0, en = 0, clr = 0, a = 0, b = 0;
   chk_state_e state;
   logic [W-1:0] pass_cnt, err_cnt, first_err_cyc;
   logic [1:0] first_err_code;
   logic err_pulse, fail;

   int n_chk = 0, n_fail = 0, n_pulse = 0;
   int m_st, m_pass, m_err, m_cyc, m_fcyc, m_fcode, m_pulse;
   logic m_aq;
   logic sa = 0;

   smpl_pair_checker #(.CNT_W(W), .ERR_LIMIT(LIM)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .a(a), .b(b),
      .state(state), .pass_cnt(pass_cnt), .err_cnt(err_cnt),
      .first_err_cyc(first_err_cyc), .first_err_code(first_err_code),
      .err_pulse(err_pulse), .fail(fail)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_st = 0; m_pass = 0; m_err = 0; m_cyc = 0; m_fcyc = 0; m_fcode = 0; m_pulse = 0; m_aq = 0;
   endtask

   // states: 0 idle, 1 sync, 2 track, 3 error
   task automatic model_edge();
      bit tf, pf;
      if (!rst_n) m_reset();
      else if (clr) begin
         m_reset();
         m_aq = a;
      end else begin
         m_pulse = 0;
         if (m_st == 0) m_st = en ? 1 : 0;
         else if (m_st == 1) begin
            m_st = en ? 2 : 0;
            m_cyc = 0;
         end else if (m_st == 2) begin
            if (!en) m_st = 0;
            else begin
               tf = (a == m_aq);
               pf = (b != a);
               if (!tf && !pf) m_pass = (m_pass + 1) % MODV;
               else begin
                  if (m_err == 0) begin
                     m_fcyc = m_cyc;
                     m_fcode = (tf ? 2 : 0) + (pf ? 1 : 0);
                  end
                  m_err = (m_err < MAXV) ? m_err + 1 : MAXV;
                  m_pulse = 1;
                  if (m_err == LIM) m_st = 3;
               end
               m_cyc = (m_cyc + 1) % MODV;
            end
         end
         m_aq = a;
      end
   endtask

   task automatic compare();
      check("state", int'(state), m_st);
      check("pass_cnt", int'(pass_cnt), m_pass);
      check("err_cnt", int'(err_cnt), m_err);
      check("first_err_cyc", int'(first_err_cyc), m_fcyc);
      check("first_err_code", int'(first_err_code), m_fcode);
      check("err_pulse", int'(err_pulse), m_pulse);
      check("fail", int'(fail), (m_st == 3) ? 1 : 0);
      if (err_pulse) n_pulse++;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare();
   endtask

   task automatic cyc(input logic e, input logic c, input logic av, input logic bv);
      en = e; clr = c; a = av; b = bv;
      step();
   endtask

   task automatic tog(input int n);
      repeat (n) begin
         sa = !sa;
         cyc(1, 0, sa, sa);
      end
   endtask

   task automatic hold(input int n);
      repeat (n) cyc(1, 0, sa, sa);
   endtask

   task automatic restart();
      cyc(0, 1, sa, sa);
      tog(2);
   endtask

   task automatic async_reset();
      #2 rst_n = 0;
      m_reset();
      #1 compare();
      check("rst_err_cnt_now", int'(err_cnt), 0);
      check("rst_state_now", int'(state), 0);
      en = 0;
      step();
      #2 rst_n = 1;
   endtask

   initial begin
      logic e, c, bb;
      m_reset();
      @(negedge clk);
      compare();
      check("reset_pass", int'(pass_cnt), 0);
      rst_n = 1;
      // golden run
      tog(20);
      check("golden_pass", int'(pass_cnt), 18);
      check("golden_err", int'(err_cnt), 0);
      check("golden_state", int'(state), 2);
      check("golden_fail", int'(fail), 0);
      // stuck a from cyc 5
      restart();
      tog(5);
      n_pulse = 0;
      hold(3);
      check("stuck_err", int'(err_cnt), 3);
      check("stuck_fcyc", int'(first_err_cyc), 5);
      check("stuck_code", int'(first_err_code), 2);
      check("stuck_pulses", n_pulse, 3);
      tog(3);
      check("stuck_pass", int'(pass_cnt), 8);
      check("stuck_pulses_after", n_pulse, 3);
      // pair break at cyc 2
      restart();
      tog(2);
      n_pulse = 0;
      sa = !sa;
      cyc(1, 0, sa, !sa);
      check("pair_code", int'(first_err_code), 1);
      check("pair_fcyc", int'(first_err_cyc), 2);
      check("pair_pulse", n_pulse, 1);
      tog(3);
      check("pair_pulse_after", n_pulse, 1);
      check("pair_pass", int'(pass_cnt), 5);
      // error limit
      restart();
      hold(3);
      check("lim_state_3", int'(state), 2);
      check("lim_fail_3", int'(fail), 0);
      hold(1);
      check("lim_state_4", int'(state), 3);
      check("lim_fail_4", int'(fail), 1);
      repeat (6) begin
         sa = !sa;
         cyc(1'($urandom % 2), 0, sa, 1'($urandom % 2));
      end
      check("lim_absorb_state", int'(state), 3);
      check("lim_absorb_err", int'(err_cnt), 4);
      cyc(1, 1, sa, sa);
      check("lim_clr_state", int'(state), 0);
      check("lim_clr_err", int'(err_cnt), 0);
      check("lim_clr_fail", int'(fail), 0);
      check("lim_clr_code", int'(first_err_code), 0);
      // en drop and re-entry
      restart();
      tog(7);
      check("drop_pass", int'(pass_cnt), 7);
      sa = !sa;
      cyc(0, 0, sa, sa);
      check("drop_idle", int'(state), 0);
      tog(1);
      check("drop_sync", int'(state), 1);
      tog(1);
      check("drop_track", int'(state), 2);
      hold(1);
      check("drop_fcyc", int'(first_err_cyc), 0);
      check("drop_pass_kept", int'(pass_cnt), 7);
      // async reset mid-track
      restart();
      hold(2);
      tog(2);
      check("mid_err", int'(err_cnt), 2);
      async_reset();
      n_pulse = 0;
      step();
      check("rel_state", int'(state), 0);
      check("rel_pulse", n_pulse, 0);
      // pass_cnt wrap
      restart();
      tog(34);
      check("wrap_pass", int'(pass_cnt), 2);
      // random traffic
      repeat (800) begin
         if ($urandom % 200 == 0) async_reset();
         else begin
            if ($urandom % 12 != 0) sa = !sa;
            e = ($urandom % 10) != 0;
            c = ($urandom % 50) == 0;
            bb = ($urandom % 12 == 0) ? !sa : sa;
            cyc(e, c, sa, bb);
         end
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
